// File: rtl/mul_div_unit_pkg.sv
// Shared operation codes, FSM state encoding and op-decoding helpers for the
// iterative multiply/divide unit.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } md_state_e;

    function automatic logic op_is_signed(input md_op_e o);
        return ~o[0];
    endfunction

    function automatic logic op_is_div(input md_op_e o);
        return o[1];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational negate-if-needed used to restore signs on product, quotient
// and remainder magnitudes.
module md_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers: one
// shift-add or restoring-divide step per cycle, fixed data-independent latency.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    import mul_div_unit_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    md_state_e          state;
    md_op_e             op_q;
    logic [CNT_W-1:0]   cnt;
    logic               sign_a, sign_b, b_zero;
    logic [WIDTH-1:0]   a_orig, mag_a, mag_b, rem;
    logic [2*WIDTH-1:0] acc;

    logic               in_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    // A plain W-bit negate is enough: -2^(W-1) maps to 2^(W-1) read unsigned.
    assign in_signed = op_is_signed(md_op_e'(op));
    assign abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;

    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b};
    assign rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];

    md_sign_fix #(.W(2*WIDTH)) u_prod_fix (.val(acc),          .neg(sign_a ^ sign_b), .res(prod_s));
    md_sign_fix #(.W(WIDTH))   u_quo_fix  (.val(acc[WIDTH-1:0]), .neg(sign_a ^ sign_b), .res(quo_s));
    md_sign_fix #(.W(WIDTH))   u_rem_fix  (.val(rem),          .neg(sign_a),          .res(rem_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= MD_MULT;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            b_zero      <= 1'b0;
            a_orig      <= '0;
            mag_a       <= '0;
            mag_b       <= '0;
            rem         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        op_q   <= md_op_e'(op);
                        cnt    <= '0;
                        sign_a <= in_signed & a[WIDTH-1];
                        sign_b <= in_signed & b[WIDTH-1];
                        b_zero <= (b == '0);
                        a_orig <= a;
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        rem    <= '0;
                        // Multiply shifts the multiplier out of the low half;
                        // divide shifts the dividend out and the quotient in.
                        acc    <= {{WIDTH{1'b0}}, op_is_div(md_op_e'(op)) ? abs_a : abs_b};
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == LAST) begin
                        state <= DONE;
                        valid <= 1'b1;
                        if (!op_is_div(op_q)) begin
                            hi          <= prod_s[2*WIDTH-1:WIDTH];
                            lo          <= prod_s[WIDTH-1:0];
                            div_by_zero <= 1'b0;
                        end else if (b_zero) begin
                            hi          <= a_orig;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            hi          <= rem_s;
                            lo          <= quo_s;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (op_is_div(op_q)) begin
                            rem               <= rem_next;
                            acc[WIDTH-1:0]    <= {acc[WIDTH-2:0], div_ge};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vectors, randomized ops
// against a 64-bit arithmetic reference, cancel, back-to-back and reset abort.
module tb_mul_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          cancel;
    logic          busy, valid, div_by_zero;
    logic [W-1:0]  hi, lo;

    int n_cmp  = 0;
    int n_fail = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .valid(valid), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: {hi, lo, div_by_zero} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint     sx = longint'($signed(x));
        longint     sy = longint'($signed(y));
        logic [63:0] p;
        logic [31:0] q, r;
        case (o)
            2'b00: begin p = 64'(sx * sy); return {p, 1'b0}; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; return {p, 1'b0}; end
            2'b10: begin
                if (y == 0) return {x, 32'hFFFF_FFFF, 1'b1};
                q = 32'(sx / sy);
                r = 32'(sx % sy);
                return {r, q, 1'b0};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF, 1'b1};
                q = x / y;
                r = x % y;
                return {r, q, 1'b0};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drives one operation from an idle unit and waits (bounded) for valid;
    // lat is the number of edges after the start edge, -1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic busy_seen);
        for (int k = 0; k < 4 && busy; k++) begin
            @(posedge clk); #1;
        end
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        busy_seen = busy;
        lat       = -1;
        for (int e = 1; e <= 200; e++) begin
            @(posedge clk); #1;
            if (valid) begin
                lat = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, valid, hi, lo, div_by_zero} !== 67'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got busy=%b valid=%b hi=%h lo=%h dbz=%b, expected all zero",
                     busy, valid, hi, lo, div_by_zero);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [31:0] xs  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7};
        logic [31:0] ys  [5] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] elo [5] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'h1, 32'hFFFF_FFFD, 32'd3};
        int   lat;
        logic bs;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], xs[i], ys[i], lat, bs);
            n_cmp++;
            if ({hi, lo, div_by_zero} !== {ehi[i], elo[i], 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL directed_%0d: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=0",
                         i, hi, lo, div_by_zero, ehi[i], elo[i]);
            end
            n_cmp++;
            if (lat !== W + 1 || bs !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL directed_latency_%0d: got %0d edges busy=%b, expected %0d edges busy=1",
                         i, lat, bs, W + 1);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int   lat;
        logic bs;
        run_op(2'b11, 32'd100, 32'd0, lat, bs);
        n_cmp++;
        if ({hi, lo, div_by_zero} !== {32'h0000_0064, 32'hFFFF_FFFF, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL div_by_zero: got hi=%h lo=%h dbz=%b, expected hi=00000064 lo=ffffffff dbz=1",
                     hi, lo, div_by_zero);
        end
        n_cmp++;
        if (lat !== W + 1) begin
            n_fail++;
            $display("[TB] FAIL div_by_zero_latency: got %0d, expected %0d", lat, W + 1);
        end
        run_op(2'b11, 32'd10, 32'd3, lat, bs);
        n_cmp++;
        if ({hi, lo, div_by_zero} !== {32'd1, 32'd3, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL dbz_clears: got hi=%h lo=%h dbz=%b, expected hi=1 lo=3 dbz=0",
                     hi, lo, div_by_zero);
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [64:0] exp;
        int          lat;
        logic        bs;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            if ($urandom_range(0, 9) == 0) y = '0;
            exp = model(o, x, y);
            run_op(o, x, y, lat, bs);
            n_cmp++;
            if ({hi, lo, div_by_zero} !== exp) begin
                n_fail++;
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b, expected hi=%h lo=%h dbz=%b",
                         i, o, x, y, hi, lo, div_by_zero, exp[64:33], exp[32:1], exp[0]);
            end
            n_cmp++;
            if (lat !== W + 1) begin
                n_fail++;
                $display("[TB] FAIL random_latency_%0d: got %0d, expected %0d", i, lat, W + 1);
            end
        end
    endtask

    task automatic test_cancel();
        int   lat;
        logic bs;
        logic saw_valid = 1'b0;
        logic busy_later = 1'b0;
        run_op(2'b11, 32'd7, 32'd2, lat, bs);
        @(posedge clk); #1;
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            saw_valid |= valid;
            if (i == 5) begin op = 2'b11; a = 32'd99; b = 32'd9; start = 1'b1; end
            if (i == 6) start = 1'b0;
        end
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        saw_valid |= valid;
        n_cmp++;
        if ({busy, saw_valid, hi, lo, div_by_zero} !== {1'b0, 1'b0, 32'd1, 32'd3, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL cancel: got busy=%b saw_valid=%b hi=%h lo=%h dbz=%b, expected busy=0 saw_valid=0 hi=1 lo=3 dbz=0",
                     busy, saw_valid, hi, lo, div_by_zero);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            busy_later |= busy | valid;
        end
        n_cmp++;
        if (busy_later !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL cancel_no_queue: got busy/valid activity=%b, expected 0", busy_later);
        end
        run_op(2'b00, 32'd6, 32'd7, lat, bs);
        n_cmp++;
        if ({hi, lo} !== {32'd0, 32'd42} || lat !== W + 1) begin
            n_fail++;
            $display("[TB] FAIL cancel_restart: got hi=%h lo=%h lat=%0d, expected hi=0 lo=2a lat=%0d",
                     hi, lo, lat, W + 1);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic        bs;
        logic [31:0] x = $urandom;
        logic [31:0] y = $urandom | 32'h1;
        logic [64:0] exp = model(2'b10, x, y);
        run_op(2'b01, 32'd3, 32'd4, lat, bs);
        @(posedge clk); #1;
        n_cmp++;
        if ({valid, busy, lo} !== {1'b0, 1'b0, 32'd12}) begin
            n_fail++;
            $display("[TB] FAIL valid_pulse: got valid=%b busy=%b lo=%h, expected valid=0 busy=0 lo=c",
                     valid, busy, lo);
        end
        run_op(2'b10, x, y, lat, bs);
        n_cmp++;
        if ({hi, lo, div_by_zero} !== exp || lat !== W + 1) begin
            n_fail++;
            $display("[TB] FAIL back_to_back: got hi=%h lo=%h dbz=%b lat=%0d, expected hi=%h lo=%h dbz=%b lat=%0d",
                     hi, lo, div_by_zero, lat, exp[64:33], exp[32:1], exp[0], W + 1);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        logic bs;
        for (int k = 0; k < 4 && busy; k++) begin
            @(posedge clk); #1;
        end
        op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, valid, hi, lo, div_by_zero} !== 67'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_calc: got busy=%b valid=%b hi=%h lo=%h dbz=%b, expected all zero",
                     busy, valid, hi, lo, div_by_zero);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bs);
        n_cmp++;
        if ({hi, lo, div_by_zero} !== {32'h0, 32'h8000_0000, 1'b0} || lat !== W + 1) begin
            n_fail++;
            $display("[TB] FAIL signed_overflow: got hi=%h lo=%h dbz=%b lat=%0d, expected hi=0 lo=80000000 dbz=0 lat=%0d",
                     hi, lo, div_by_zero, lat, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_random();
        test_cancel();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
